uart_packet_assembler: RTL

- Sits directly upstream of the PLANK top-level command decoder.
- Takes the registered byte stream from uart_rx, frames it into fixed-length packets and verifies a trailing checksum.
- Presents each good packet as one wide little-endian word with a single-cycle valid strobe.
- Discards and flags bad or stalled packets so that downstream attenuator, phase and inhibit registers never load partial data.

---
 rtl/plank_pkg.sv | 23 ++
 rtl/pkt_timeout_counter.sv | 48 ++++
 rtl/uart_packet_assembler.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/plank_pkg.sv
// Shared definitions for the PLANK UART packet path: state encoding,
// default packet geometry/timeout and the checksum accumulate helper.
package plank_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_CHECK   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_COLLECT = ST_COLLECT,
        S_CHECK   = ST_CHECK
    } pkt_state_e;

    localparam int PLANK_PKT_LEN      = 19;
    localparam int PLANK_TIMEOUT_CLKS = 100000;

    // Modulo-256 running checksum step.
    function automatic logic [7:0] plank_sum8(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/pkt_timeout_counter.sv
// Saturating watchdog counter with synchronous clear and increment enable.
// o_hit flags the increment that lands exactly on LIMIT, so a caller can act
// in the same cycle the limit is reached; o_expired flags a saturated count.
module pkt_timeout_counter
    import plank_pkg::*;
#(
    parameter int LIMIT = PLANK_TIMEOUT_CLKS,
    parameter int CW    = $clog2(LIMIT + 1)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired,
    output logic o_hit
);

    localparam logic [CW-1:0] LIMIT_C    = CW'(LIMIT);
    localparam logic [CW-1:0] LIMIT_M1_C = CW'(LIMIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear has priority, otherwise count up and stick at LIMIT.
    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_inc && (count_q != LIMIT_C)) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_hit     = i_inc && (count_q == LIMIT_M1_C);
    assign o_expired = (count_q == LIMIT_C);

endmodule

// File: rtl/uart_packet_assembler.sv
// Frames the uart_rx byte stream into fixed-length packets, verifies the
// trailing modulo-256 checksum and publishes good packets as one wide
// little-endian word. Bad or stalled packets are dropped with an error pulse.
// Optional statistics counters are built when PLANK_PKT_STATS_EN is defined.
module uart_packet_assembler
    import plank_pkg::*;
#(
    parameter int RX_PACKET_LEN = PLANK_PKT_LEN,
    parameter int TIMEOUT_CLKS  = PLANK_TIMEOUT_CLKS
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic [7:0]                 i_uart_rx_data,
    input  logic                       i_uart_rx_valid,
    output logic [RX_PACKET_LEN*8-1:0] o_data,
    output logic                       o_data_valid,
    output logic                       o_uart_rx_error,
    output logic [15:0]                o_good_count,
    output logic [15:0]                o_err_count
);

    localparam int DW = RX_PACKET_LEN * 8;
    localparam int SW = (RX_PACKET_LEN - 1) * 8;
    localparam int IW = $clog2(RX_PACKET_LEN);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(RX_PACKET_LEN - 1);

    pkt_state_e    state_q,  state_d;
    logic [IW-1:0] idx_q,    idx_d;
    logic [7:0]    sum_q,    sum_d;
    logic [SW-1:0] shadow_q, shadow_d;
    logic [DW-1:0] data_q,   data_d;
    logic          valid_q,  valid_d;
    logic          err_q,    err_d;

    logic          strobe_s;
    logic [SW-1:0] shift_s;
    logic          tmo_inc_s;
    logic          tmo_clr_s;
    logic          tmo_hit_s;
    logic          tmo_expired_s;
    logic          tmo_fire_s;

    // Payload bytes enter at the top so byte 0 ends up in the low lane.
    assign shift_s  = SW'({i_uart_rx_data, shadow_q} >> 8);
    assign strobe_s = i_en && i_uart_rx_valid;

    // The watchdog only runs while a packet is open and the line is quiet.
    assign tmo_inc_s  = (state_q == S_COLLECT) && i_en && !i_uart_rx_valid;
    assign tmo_clr_s  = !tmo_inc_s || tmo_fire_s;
    assign tmo_fire_s = tmo_inc_s && (tmo_hit_s || tmo_expired_s);

    pkt_timeout_counter #(
        .LIMIT (TIMEOUT_CLKS),
        .CW    (TW)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (tmo_clr_s),
        .i_inc     (tmo_inc_s),
        .o_expired (tmo_expired_s),
        .o_hit     (tmo_hit_s)
    );

    // Packet FSM next state. The checksum verdict is taken on the final
    // byte's strobe and registered, so the CHECK cycle is the cycle in which
    // o_data_valid / o_uart_rx_error are presented.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE, S_CHECK: begin
                if (strobe_s) begin
                    shadow_d = shift_s;
                    sum_d    = i_uart_rx_data;
                    idx_d    = IW'(1);
                    state_d  = S_COLLECT;
                end else begin
                    sum_d    = 8'd0;
                    idx_d    = '0;
                    state_d  = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (!i_en) begin
                    sum_d   = 8'd0;
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else if (i_uart_rx_valid) begin
                    if (idx_q == LAST_IDX) begin
                        sum_d   = 8'd0;
                        idx_d   = '0;
                        state_d = S_CHECK;
                        if (i_uart_rx_data == sum_q) begin
                            data_d  = {i_uart_rx_data, shadow_q};
                            valid_d = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                        end
                    end else begin
                        shadow_d = shift_s;
                        sum_d    = plank_sum8(sum_q, i_uart_rx_data);
                        idx_d    = idx_q + IW'(1);
                        state_d  = S_COLLECT;
                    end
                end else if (tmo_fire_s) begin
                    err_d   = 1'b1;
                    sum_d   = 8'd0;
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_COLLECT;
                end
            end
            default: begin
                sum_d   = 8'd0;
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Packet FSM and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            sum_q    <= 8'd0;
            shadow_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sum_q    <= sum_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign o_data          = data_q;
    assign o_data_valid    = valid_q;
    assign o_uart_rx_error = err_q;

`ifdef PLANK_PKT_STATS_EN
    logic [15:0] good_cnt_q, good_cnt_d;
    logic [15:0] err_cnt_q,  err_cnt_d;

    // Saturating statistics, stepped together with the pulses they count.
    always_comb begin
        good_cnt_d = good_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (valid_d && (good_cnt_q != 16'hFFFF)) begin
            good_cnt_d = good_cnt_q + 16'd1;
        end else begin
            good_cnt_d = good_cnt_q;
        end
        if (err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            good_cnt_q <= 16'd0;
            err_cnt_q  <= 16'd0;
        end else begin
            good_cnt_q <= good_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign o_good_count = good_cnt_q;
    assign o_err_count  = err_cnt_q;
`else
    assign o_good_count = 16'd0;
    assign o_err_count  = 16'd0;
`endif

endmodule
